// File: rtl/cell_plotter.sv
// Turns cell-state updates into VGA pixel writes through a small FIFO,
// and paints the whole field dead after reset or on clear_req.
module cell_plotter #(
  parameter int         WIDTH        = 160,
  parameter int         HEIGHT       = 120,
  parameter int         DEPTH        = 16,
  parameter logic [2:0] ALIVE_COLOUR = 3'b111,
  parameter logic [2:0] DEAD_COLOUR  = 3'b000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_x,
  input  logic [7:0] in_y,
  input  logic       in_alive,
  input  logic       clear_req,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic [7:0] oob_count
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [7:0] X_LIMIT = 8'(WIDTH);
  localparam logic [7:0] Y_LIMIT = 8'(HEIGHT);
  localparam logic [7:0] LAST_X  = 8'(WIDTH - 1);
  localparam logic [6:0] LAST_Y  = 7'(HEIGHT - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t      state_q;
  logic [7:0]  cx_q;
  logic [6:0]  cy_q;
  logic [15:0] mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [15:0] stage_q;
  logic        stage_valid_q;
  logic [7:0]  x_q;
  logic [6:0]  y_q;
  logic [2:0]  colour_q;
  logic        plot_q;
  logic [7:0]  oob_q, oob_d;

  logic fifo_empty, fifo_full, accept, oob, push, pop;

  assign fifo_empty = (wr_q == rd_q);
  assign fifo_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign in_ready   = (state_q == RUN) && !fifo_full;
  assign accept     = in_valid && in_ready;
  assign oob        = (in_x >= X_LIMIT) || (in_y >= Y_LIMIT);
  assign push       = accept && !oob;
  assign pop        = (state_q == RUN) && !fifo_empty;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    oob_d = oob_q;
    if (push) wr_d = wr_q + (AW+1)'(1);
    if (pop)  rd_d = rd_q + (AW+1)'(1);
    // The flush also swallows any push made in the clear_req cycle.
    if (clear_req) begin
      wr_d = '0;
      rd_d = '0;
    end
    if (accept && oob && (oob_q != 8'hFF)) oob_d = oob_q + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {in_x, in_y[6:0], in_alive};
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= CLEAR;
      cx_q          <= '0;
      cy_q          <= '0;
      wr_q          <= '0;
      rd_q          <= '0;
      oob_q         <= '0;
      stage_q       <= '0;
      stage_valid_q <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      colour_q      <= DEAD_COLOUR;
      plot_q        <= 1'b0;
    end else begin
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      oob_q         <= oob_d;
      stage_q       <= mem_q[rd_q[AW-1:0]];
      stage_valid_q <= pop;
      plot_q        <= 1'b0;
      // A popped entry left over from a clear_req cycle goes out before the
      // sweep starts, holding the sweep counters for that one cycle.
      if (stage_valid_q) begin
        x_q      <= stage_q[15:8];
        y_q      <= stage_q[7:1];
        colour_q <= stage_q[0] ? ALIVE_COLOUR : DEAD_COLOUR;
        plot_q   <= 1'b1;
      end else if (state_q == CLEAR) begin
        x_q      <= cx_q;
        y_q      <= cy_q;
        colour_q <= DEAD_COLOUR;
        plot_q   <= 1'b1;
        if (cx_q == LAST_X) begin
          cx_q <= '0;
          if (cy_q == LAST_Y) begin
            cy_q    <= '0;
            state_q <= RUN;
          end else begin
            cy_q <= cy_q + 7'd1;
          end
        end else begin
          cx_q <= cx_q + 8'd1;
        end
      end
      if (clear_req) begin
        state_q <= CLEAR;
        cx_q    <= '0;
        cy_q    <= '0;
      end
    end
  end

  assign vga_x      = x_q;
  assign vga_y      = y_q;
  assign vga_colour = colour_q;
  assign vga_plot   = plot_q;
  assign oob_count  = oob_q;
  assign busy       = (state_q == CLEAR) || !fifo_empty || stage_valid_q || plot_q;

endmodule

// File: tb/tb_cell_plotter.sv
// Scoreboard bench for cell_plotter: stimulus queues expected pixels,
// a forked monitor compares every vga_plot pulse in order.
module tb_cell_plotter;

  localparam int W = 160;
  localparam int H = 120;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_x;
  logic [7:0] in_y;
  logic       in_alive;
  logic       clear_req;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic [7:0] oob_count;

  int errors = 0;
  int checks = 0;
  logic [17:0] expQ [$];

  always #5 clock = ~clock;

  cell_plotter dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_alive   (in_alive),
    .clear_req  (clear_req),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .oob_count  (oob_count)
  );

  task automatic checkOutput(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, wanted %0d", name, actual, required);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic pushExpected(input int x, input int y, input int c);
    expQ.push_back({8'(x), 7'(y), 3'(c)});
  endtask

  task automatic pushSweep(input int n);
    for (int k = 0; k < n; k++) pushExpected(k % W, k / W, 0);
  endtask

  // Holds the update until in_ready, then lets one edge accept it.
  task automatic applyStimulus(input int x, input int y, input bit alive, input bit expectPlot);
    int waitCycles;
    waitCycles = 0;
    in_valid = 1'b1;
    in_x     = 8'(x);
    in_y     = 8'(y);
    in_alive = alive;
    while (!in_ready && waitCycles < 100) begin
      tick();
      waitCycles++;
    end
    if (!in_ready) begin
      checkOutput("accept timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    if (expectPlot && x < W && y < H) pushExpected(x, y, alive ? 7 : 0);
    tick();
  endtask

  task automatic waitDrain(input int bound, input string name);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    checkOutput(name, expQ.size(), 0);
    expQ.delete();
  endtask

  initial begin
    int n;
    fork
      forever begin
        logic [17:0] expPix;
        @(negedge clock);
        if (vga_plot === 1'b1) begin
          checks++;
          if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected plot: got (%0d,%0d,%0d), wanted no plot",
                     vga_x, vga_y, vga_colour);
          end else begin
            expPix = expQ.pop_front();
            if ({vga_x, vga_y, vga_colour} !== expPix) begin
              errors++;
              $display("[TB] FAIL plot: got (%0d,%0d,%0d), wanted (%0d,%0d,%0d)",
                       vga_x, vga_y, vga_colour, expPix[17:10], expPix[9:3], expPix[2:0]);
            end
          end
        end
      end
    join_none

    reset_n  = 1'b0;
    in_x     = '0;
    in_y     = '0;
    in_alive = 1'b0;
    idle();
    repeat (3) tick();
    checkOutput("reset vga_plot", int'(vga_plot), 0);
    checkOutput("reset vga_x", int'(vga_x), 0);
    checkOutput("reset vga_y", int'(vga_y), 0);
    checkOutput("reset vga_colour", int'(vga_colour), 0);
    checkOutput("reset oob_count", int'(oob_count), 0);
    checkOutput("reset in_ready", int'(in_ready), 0);
    checkOutput("reset busy", int'(busy), 1);

    $display("[TB] initial sweep");
    pushSweep(W * H);
    reset_n = 1'b1;
    n = 0;
    while (!in_ready && n < 20000) begin
      tick();
      n++;
    end
    checkOutput("cycles until in_ready", n, W * H);
    waitDrain(10, "initial sweep drained");

    $display("[TB] back-to-back updates to one cell");
    applyStimulus(5, 7, 1'b1, 1'b1);
    applyStimulus(5, 7, 1'b0, 1'b1);
    idle();
    tick();
    checkOutput("first plot latency", int'(vga_plot), 1);
    checkOutput("first plot colour", int'(vga_colour), 7);
    tick();
    checkOutput("second plot colour", int'(vga_colour), 0);
    checkOutput("busy while plotting", int'(busy), 1);
    tick();
    checkOutput("busy after last plot", int'(busy), 0);
    waitDrain(10, "pair drained");

    applyStimulus(159, 119, 1'b1, 1'b1);
    applyStimulus(0, 0, 1'b1, 1'b1);
    idle();
    waitDrain(10, "corner cells drained");

    $display("[TB] out-of-range updates");
    applyStimulus(160, 3, 1'b1, 1'b1);
    applyStimulus(2, 120, 1'b1, 1'b1);
    idle();
    checkOutput("oob_count after two", int'(oob_count), 2);
    for (int i = 0; i < 300; i++) applyStimulus(160 + (i % 96), i % 256, 1'b1, 1'b1);
    idle();
    checkOutput("oob_count saturated", int'(oob_count), 255);
    repeat (4) tick();

    $display("[TB] full FIFO with pop held off");
    force dut.pop = 1'b0;
    for (int i = 0; i < 16; i++) applyStimulus(i * 3, i + 1, i[0], 1'b1);
    idle();
    checkOutput("in_ready when full", int'(in_ready), 0);
    checkOutput("busy when full", int'(busy), 1);
    in_valid = 1'b1;
    in_x     = 8'd20;
    in_y     = 8'd20;
    in_alive = 1'b1;
    tick();
    idle();
    release dut.pop;
    waitDrain(50, "full FIFO drained");
    repeat (3) tick();

    $display("[TB] clear_req on first pop, then mid-sweep restart");
    applyStimulus(10, 20, 1'b1, 1'b1);
    in_x      = 8'd11;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    pushSweep(10 * W + 41);
    in_x = 8'd12;
    checkOutput("in_ready after clear", int'(in_ready), 0);
    tick();
    in_x = 8'd13;
    checkOutput("in_ready during sweep", int'(in_ready), 0);
    tick();
    idle();
    n = 0;
    while (!(vga_plot && vga_x == 8'd39 && vga_y == 7'd10) && n < 3000) begin
      tick();
      n++;
    end
    checkOutput("sweep reached (39,10)", int'(n < 3000), 1);
    clear_req = 1'b1;
    pushSweep(W * H);
    tick();
    clear_req = 1'b0;
    waitDrain(20000, "restarted sweep drained");
    repeat (2) tick();
    checkOutput("in_ready after restarted sweep", int'(in_ready), 1);

    $display("[TB] reset during drain");
    applyStimulus(1, 2, 1'b1, 1'b1);
    applyStimulus(3, 4, 1'b0, 1'b0);
    applyStimulus(5, 6, 1'b1, 1'b0);
    idle();
    reset_n = 1'b0;
    tick();
    checkOutput("drain reset vga_plot", int'(vga_plot), 0);
    checkOutput("drain reset vga_x", int'(vga_x), 0);
    checkOutput("drain reset oob_count", int'(oob_count), 0);
    checkOutput("drain reset in_ready", int'(in_ready), 0);
    checkOutput("drain reset busy", int'(busy), 1);
    pushSweep(W * H);
    reset_n = 1'b1;
    waitDrain(19300, "post-reset sweep drained");
    repeat (5) tick();
    checkOutput("final busy", int'(busy), 0);
    checkOutput("final in_ready", int'(in_ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cell_plotter.md
# cell_plotter

Downstream stage of the Life simulation core. It accepts cell-state updates, one cell coordinate plus its new alive/dead state per transfer, and buffers them in a small FIFO. It drains them as single-pixel writes toward the VGA adapter (x 8-bit, y 7-bit, colour 3-bit, plot strobe). It also paints the whole 160x120 field dead after reset or on request, so the screen matches the cleared cell array.

## Interface
- WIDTH, 160, field width in cells; valid in_x is 0..WIDTH-1
- HEIGHT, 120, field height in cells; valid in_y is 0..HEIGHT-1
- DEPTH, 16, FIFO entries; must be a power of two, at least 2
- ALIVE_COLOUR, 3'b111, colour for live cells
- DEAD_COLOUR, 3'b000, colour for dead cells and for the clear sweep
- clock  in  1  system clock, rising edge
- reset_n  in  1  reset, synchronous, active-low
- in_valid  in  1  upstream update present
- in_ready  out  1  block accepts the update this cycle
- in_x  in  8  cell column
- in_y  in  8  cell row
- in_alive  in  1  new cell state: 1 alive, 0 dead
- clear_req  in  1  single-cycle request to repaint the field dead
- vga_x  out  8  pixel column, registered
- vga_y  out  7  pixel row, registered
- vga_colour  out  3  pixel colour, registered
- vga_plot  out  1  pixel write strobe, registered, one pixel per cycle high
- busy  out  1  clear in progress, FIFO non-empty, or vga_plot high
- oob_count  out  8  saturating count of discarded out-of-range updates

## Operation
- The FSM has two states.
  - CLEAR sweeps the field.
  - RUN accepts and plots updates.
  - Reset state is CLEAR, with sweep counters cx=0 and cy=0.
- CLEAR:
  - Every cycle, emit a pixel at (cx,cy) with DEAD_COLOUR.
  - cx increments 0..WIDTH-1. On wrap, cx returns to 0 and cy increments.
  - After emitting (WIDTH-1,HEIGHT-1), go to RUN.
  - in_ready is 0. The FIFO is not popped.
- RUN:
  - A transfer occurs when in_valid and in_ready are both 1.
  - in_ready = FIFO not full. There is no bypass when full, even if a pop happens the same cycle.
  - If the transferred in_x>=WIDTH or in_y>=HEIGHT, the update is consumed but not queued, and oob_count increments, saturating at 255.
  - Otherwise {in_x, in_y[6:0], in_alive} is pushed.
  - If the FIFO is non-empty, pop one entry per cycle. The next cycle, drive vga_x/vga_y from the entry, vga_colour = alive ? ALIVE_COLOUR : DEAD_COLOUR, and vga_plot=1.
  - Updates are plotted in strict arrival order, so the last update to a coordinate wins.
- Push and pop in the same cycle leave the FIFO level unchanged.
- clear_req:
  - Sampled in any state. The next cycle the state is CLEAR with cx=cy=0, and the FIFO is flushed to empty.
  - A pop happening in the clear_req cycle still produces its plot; a push in that cycle is discarded by the flush.
  - clear_req during CLEAR restarts the sweep from (0,0).
- oob_count is cleared only by reset.

## Timing
- Reset values:
  - vga_plot=0, vga_x=0, vga_y=0, vga_colour=DEAD_COLOUR, oob_count=0.
  - FIFO is empty.
  - in_ready=0 (the state is CLEAR) and busy=1.
- Sweep timing:
  - The first clock edge with reset_n=1 registers pixel (0,0). The sweep's last pixel (159,119) is on the outputs 19200 cycles later, counted inclusively.
  - in_ready rises in the cycle after the last sweep pixel is registered.
- Update latency: an update accepted at edge N is popped at edge N+1 at the earliest and appears on vga_* after edge N+2, so it is visible in cycle N+2.
- Throughput: one plot per cycle while the FIFO is non-empty. Sustained input at 1/cycle never fills the FIFO.
- Backpressure: with DEPTH entries queued and no pop, in_ready=0 combinationally. This cannot occur in RUN unless the FIFO is filling faster than it drains, which is impossible at one push per cycle; in practice it is reachable only via a stalled pop, which the block does not have.
  - The verification engineer still checks the full flag by forcing pop-inhibit through a bench force on the internal empty/pop path.
- busy falls the cycle after the final vga_plot pulse.
- reset_n low mid-sweep or mid-drain: the next edge restores all reset values, and the sweep restarts.

## Test plan
- Reset, then release reset_n -> exactly 19200 vga_plot pulses in raster order, (0,0) first and (159,119) last, all colour 000; in_ready=0 throughout, then 1.
- After the sweep, send (5,7,alive=1) then (5,7,alive=0) on back-to-back cycles -> plots on consecutive cycles: (5,7,111) then (5,7,000), the first two cycles after its acceptance; busy then drops.
- Send (160,3,1) and (2,120,1) -> both accepted and no plot; oob_count=2. Then send 300 out-of-range updates -> oob_count saturates at 255.
- Queue 4 valid updates, then pulse clear_req in the cycle the first is popped -> the first update is plotted, the other three are never plotted, and a full sweep starting at (0,0) follows.
- Pulse clear_req mid-sweep at pixel (40,10) -> the next plotted pixel is (0,0) and the sweep totals 19200 pixels from the restart.
- Assert reset_n=0 for one cycle during a drain -> the next cycle has vga_plot=0 and the FIFO empty; the sweep restarts from (0,0).
